regfile_32x32: RTL and testbench



---
 rtl/regfile_32x32.sv | 66 ++++++
 tb/tb_regfile_32x32.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/regfile_32x32.sv
// 32-entry register file: one synchronous write port, two combinational read ports.
// Entry 0 reads as zero and holds no state. BYPASS=1 forwards write data to a matching read.
module regfile_32x32 #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int BYPASS    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RegWrite,
    input  logic [ADDR_BITS-1:0] WriteRegister,
    input  logic [WIDTH-1:0]     WriteData,
    input  logic [ADDR_BITS-1:0] ReadRegister1,
    input  logic [ADDR_BITS-1:0] ReadRegister2,
    output logic [WIDTH-1:0]     ReadData1,
    output logic [WIDTH-1:0]     ReadData2
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0] regs_q [1:DEPTH-1];
    logic [WIDTH-1:0] regs_d [1:DEPTH-1];
    logic [DEPTH-1:1] wr_en;
    logic             byp_1;
    logic             byp_2;
    logic [WIDTH-1:0] rd_1;
    logic [WIDTH-1:0] rd_2;

    // One-hot write decode; index 0 has no enable so writes to it vanish.
    always_comb begin
        for (int i = 1; i < DEPTH; i++) begin
            wr_en[i]  = RegWrite && (WriteRegister == i[ADDR_BITS-1:0]);
            regs_d[i] = wr_en[i] ? WriteData : regs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < DEPTH; i++) begin
            if (reset) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        rd_1 = '0;
        rd_2 = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (ReadRegister1 == i[ADDR_BITS-1:0]) rd_1 = regs_q[i];
            if (ReadRegister2 == i[ADDR_BITS-1:0]) rd_2 = regs_q[i];
        end
    end

    always_comb begin
        byp_1 = (BYPASS != 0) && !reset && RegWrite
                && (WriteRegister == ReadRegister1) && (ReadRegister1 != '0);
        byp_2 = (BYPASS != 0) && !reset && RegWrite
                && (WriteRegister == ReadRegister2) && (ReadRegister2 != '0);
    end

    assign ReadData1 = byp_1 ? WriteData : rd_1;
    assign ReadData2 = byp_2 ? WriteData : rd_2;

endmodule

// File: tb/tb_regfile_32x32.sv
// Self-checking bench for regfile_32x32: one instance without and one with forwarding,
// checked every cycle against an array model plus directed literal expectations.
module tb_regfile_32x32;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] rd1_n, rd2_n, rd1_b, rd2_b;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [32];
    logic        model_valid = 1'b0;

    always #5 clk = ~clk;

    regfile_32x32 #(.WIDTH(32), .ADDR_BITS(5), .BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_n), .ReadData2(rd2_n));

    regfile_32x32 #(.WIDTH(32), .ADDR_BITS(5), .BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_b), .ReadData2(rd2_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What a read must return right now, given the stored model and current inputs.
    function automatic logic [31:0] expect_read(input logic [4:0] a, input bit fwd);
        if (a == 0) return 32'h0;
        if (fwd && !reset && RegWrite && WriteRegister == a) return WriteData;
        return mem[a];
    endfunction

    task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        reset = r; RegWrite = we; WriteRegister = wa; WriteData = wd;
        ReadRegister1 = a1; ReadRegister2 = a2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        fork
            // Model: state changes only at a rising edge.
            forever begin
                @(posedge clk);
                if (reset) begin
                    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
                    model_valid = 1'b1;
                end else if (RegWrite && WriteRegister != 0) begin
                    mem[WriteRegister] = WriteData;
                end
            end
            // Every-cycle compare, mid-cycle while inputs are stable.
            forever begin
                @(negedge clk);
                if (model_valid) begin
                    check("cyc_rd1_nobyp", rd1_n, expect_read(ReadRegister1, 1'b0));
                    check("cyc_rd2_nobyp", rd2_n, expect_read(ReadRegister2, 1'b0));
                    check("cyc_rd1_byp",   rd1_b, expect_read(ReadRegister1, 1'b1));
                    check("cyc_rd2_byp",   rd2_b, expect_read(ReadRegister2, 1'b1));
                end
            end
        join_none

        tick;
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        tick;
        drive(1'b0, 1'b0, 5'd5, 32'h0, 5'd5, 5'd0);
        #1 check("pre_reset_r5", rd1_n, 32'hDEADBEEF);
        drive(1'b1, 1'b1, 5'd5, 32'h11111111, 5'd5, 5'd5);
        #1 check("reset_not_yet", rd1_n, 32'hDEADBEEF);
        tick;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        #1 check("reset_r5", rd1_n, 32'h0);
        check("model_reset_r5", mem[5], 32'h0);
        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = a[4:0];
            ReadRegister2 = 5'(31 - a);
            #1;
            check("reset_all_rd1", rd1_n, 32'h0);
            check("reset_all_rd2", rd2_b, 32'h0);
        end

        drive(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd8);
        tick;
        drive(1'b0, 1'b0, 5'd7, 32'hFFFFFFFF, 5'd7, 5'd8);
        #1 check("write_r7", rd1_n, 32'h12345678);
        check("write_r8_zero", rd2_n, 32'h0);
        check("model_r7", mem[7], 32'h12345678);
        tick;
        check("wr_disabled_r7", rd1_n, 32'h12345678);
        check("wr_disabled_byp", rd1_b, 32'h12345678);

        drive(1'b0, 1'b1, 5'd0, 32'hA5A5A5A5, 5'd0, 5'd0);
        #1 check("r0_byp_pre", rd1_b, 32'h0);
        tick;
        check("r0_post_n", rd1_n, 32'h0);
        check("r0_post_b", rd2_b, 32'h0);

        for (int k = 1; k < 32; k++) begin
            drive(1'b0, 1'b1, 5'(k), 32'(k), 5'd0, 5'd0);
            tick;
        end
        RegWrite = 1'b0;
        for (int k = 0; k < 32; k++) begin
            ReadRegister1 = 5'(k);
            ReadRegister2 = 5'(k);
            #1;
            check("decode_rd1", rd1_n, 32'(k));
            check("decode_rd2", rd2_b, 32'(k));
        end

        drive(1'b0, 1'b1, 5'd3, 32'h1, 5'd3, 5'd3);
        tick;
        drive(1'b0, 1'b1, 5'd3, 32'h2, 5'd3, 5'd3);
        #1 check("byp_rd1_pre", rd1_b, 32'h2);
        check("byp_rd2_pre", rd2_b, 32'h2);
        check("nobyp_rd1_pre", rd1_n, 32'h1);
        tick;
        RegWrite = 1'b0;
        #1 check("nobyp_rd1_post", rd1_n, 32'h2);

        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0,
                  5'($urandom), $urandom, 5'($urandom), 5'($urandom));
            if ($urandom_range(0, 3) == 0) ReadRegister1 = WriteRegister;
            if ($urandom_range(0, 3) == 0) ReadRegister2 = WriteRegister;
            tick;
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
